// File: rtl/capture_fifo_pkg.sv
// capture_fifo_pkg: register offsets, STATUS/CTRL bit positions and
// counter widths shared by the capture FIFO block.
package capture_fifo_pkg;

  localparam logic [3:0] OFF_DATA   = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_CTRL   = 4'h8;
  localparam logic [3:0] OFF_THRESH = 4'hC;

  typedef enum logic [1:0] {
    REG_DATA   = OFF_DATA[3:2],
    REG_STATUS = OFF_STATUS[3:2],
    REG_CTRL   = OFF_CTRL[3:2],
    REG_THRESH = OFF_THRESH[3:2]
  } reg_sel_e;

  localparam int ST_LEVEL_W  = 13;
  localparam int ST_EMPTY    = 16;
  localparam int ST_FULL     = 17;
  localparam int ST_OVF      = 18;
  localparam int ST_DROP_LSB = 24;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_FLUSH = 1;
  localparam int CTRL_CLR   = 2;

  localparam int DROP_W = 8;

endpackage

// File: rtl/capture_fifo_ram.sv
// capture_fifo_ram: simple dual-port RAM, one sync write and one sync read.
// Ports: clk, we/waddr/wdata write port, re/raddr read port, q read data.
module capture_fifo_ram
  import capture_fifo_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_W-1:0]     q
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) q <= mem[raddr];
  end

endmodule

// File: rtl/capture_fifo_apb.sv
// capture_fifo_apb: sample capture FIFO with an APB3 register window.
// Ports: CLK50, RESET (sync, high), WR_VALID/WR_DATA capture input,
// APB3 slave (PSEL..PSLVERR), FULL/EMPTY status, IRQ threshold level.
// Optional macro CAPTURE_FIFO_THRESH_IRQ_EN enables THRESH and IRQ.
module capture_fifo_apb
  import capture_fifo_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 9
) (
  input  logic              CLK50,
  input  logic              RESET,
  input  logic              WR_VALID,
  input  logic [DATA_W-1:0] WR_DATA,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [3:0]        PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              FULL,
  output logic              EMPTY,
  output logic              IRQ
);

  localparam int PW = DEPTH_LOG2 + 1;

  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW-1:0]     wr_nxt, rd_nxt;
  logic [PW-1:0]     level;
  logic              enable, en_nxt;
  logic              ovf;
  logic [DROP_W-1:0] drop_cnt;
  logic              setup_q;
  logic              rd_ok;
  logic [DATA_W-1:0] ram_q;
  logic [31:0]       status;
  logic [31:0]       thresh_rd;
  reg_sel_e          sel;
  logic              access, wr_acc, rd_acc;
  logic              ctrl_wr, flush, clr;
  logic              push, pop, drop;
  logic              unused_ok;

  assign unused_ok = &{1'b0, PADDR[1:0], PWDATA[31:3]};

  assign sel    = reg_sel_e'(PADDR[3:2]);
  // An access only counts if its setup phase was seen after reset.
  assign access = PSEL & PENABLE & setup_q & ~RESET;
  assign wr_acc = access & PWRITE;
  assign rd_acc = access & ~PWRITE;

  assign ctrl_wr = wr_acc & (sel == REG_CTRL);
  assign flush   = ctrl_wr & PWDATA[CTRL_FLUSH];
  assign clr     = ctrl_wr & PWDATA[CTRL_CLR];
  assign en_nxt  = ctrl_wr ? PWDATA[CTRL_EN] : enable;

  assign push = WR_VALID & enable & ~FULL;
  assign drop = WR_VALID & enable & FULL;
  // rd_ok holds the head availability latched in the setup phase.
  assign pop  = rd_acc & (sel == REG_DATA) & rd_ok;

  assign level  = wr_ptr - rd_ptr;
  assign PREADY = 1'b1;

  always_comb begin
    wr_nxt = wr_ptr + PW'(push);
    rd_nxt = rd_ptr + PW'(pop);
    if (flush) begin
      wr_nxt = '0;
      rd_nxt = '0;
    end
  end

  always_ff @(posedge CLK50) begin
    if (RESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      FULL     <= 1'b0;
      EMPTY    <= 1'b1;
      enable   <= 1'b0;
      ovf      <= 1'b0;
      drop_cnt <= '0;
      setup_q  <= 1'b0;
      rd_ok    <= 1'b0;
    end else begin
      wr_ptr  <= wr_nxt;
      rd_ptr  <= rd_nxt;
      FULL    <= (wr_nxt[PW-1] != rd_nxt[PW-1]) &&
                 (wr_nxt[PW-2:0] == rd_nxt[PW-2:0]);
      EMPTY   <= (wr_nxt == rd_nxt);
      enable  <= en_nxt;
      setup_q <= PSEL & ~PENABLE;
      rd_ok   <= ~EMPTY;
      if (clr) begin
        ovf      <= 1'b0;
        drop_cnt <= '0;
      end else if (drop) begin
        ovf <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  capture_fifo_ram #(
    .DATA_W    (DATA_W),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk  (CLK50),
    .we   (push),
    .waddr(wr_ptr[DEPTH_LOG2-1:0]),
    .wdata(WR_DATA),
    .re   (PSEL & ~PENABLE),
    .raddr(rd_ptr[DEPTH_LOG2-1:0]),
    .q    (ram_q)
  );

`ifdef CAPTURE_FIFO_THRESH_IRQ_EN
  logic [PW-1:0] thresh, th_nxt, level_nxt;

  assign th_nxt    = (wr_acc && sel == REG_THRESH) ?
                     PWDATA[PW-1:0] : thresh;
  assign level_nxt = wr_nxt - rd_nxt;
  assign thresh_rd = 32'(thresh);

  // Built from next-state values so IRQ tracks level with no extra lag.
  always_ff @(posedge CLK50) begin
    if (RESET) begin
      thresh <= '0;
      IRQ    <= 1'b0;
    end else begin
      thresh <= th_nxt;
      IRQ    <= en_nxt && (level_nxt >= th_nxt) && (th_nxt != '0);
    end
  end
`else
  assign thresh_rd = '0;
  assign IRQ       = 1'b0;
`endif

  always_comb begin
    status = '0;
    status[ST_LEVEL_W-1:0] = ST_LEVEL_W'(level);
    status[ST_EMPTY]       = EMPTY;
    status[ST_FULL]        = FULL;
    status[ST_OVF]         = ovf;
    status[ST_DROP_LSB +: DROP_W] = drop_cnt;
  end

  always_comb begin
    PRDATA = '0;
    if (rd_acc) begin
      unique case (sel)
        REG_DATA:   PRDATA = rd_ok ? 32'(ram_q) : 32'd0;
        REG_STATUS: PRDATA = status;
        REG_CTRL:   PRDATA = 32'(enable);
        REG_THRESH: PRDATA = thresh_rd;
      endcase
    end
  end

  assign PSLVERR = (rd_acc & (sel == REG_DATA) & ~rd_ok) |
                   (wr_acc & ((sel == REG_DATA) | (sel == REG_STATUS)));

endmodule

// File: tb/tb_capture_fifo_apb.sv
// tb_capture_fifo_apb: randomized + directed bench for capture_fifo_apb
// against a queue-based reference model (DEPTH_LOG2=2, DATA_W=16).
module tb_capture_fifo_apb;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic [15:0] wr_data = '0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [3:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready, pslverr, full, empty, irq;

  int checks = 0;
  int failures = 0;
  bit push_mode = 1'b0;

  always #10 clk = ~clk;

  capture_fifo_apb #(.DATA_W(16), .DEPTH_LOG2(2)) dut (
    .CLK50(clk), .RESET(rst), .WR_VALID(wr_valid), .WR_DATA(wr_data),
    .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite), .PADDR(paddr),
    .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready),
    .PSLVERR(pslverr), .FULL(full), .EMPTY(empty), .IRQ(irq)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference model: FIFO contents as a queue plus register shadows.
  logic [15:0] q[$];
  bit m_en, m_ovf, m_setup, m_hasdata, m_irq;
  int m_drop, m_th;

  always @(negedge clk) begin
    int sz;
    bit acc, push, pop, dropev, ctrlw, exp_err;
    logic [1:0] s;
    logic [31:0] exp_rd;
    if (rst) begin
      q.delete();
      m_en = 0; m_ovf = 0; m_setup = 0; m_hasdata = 0; m_irq = 0;
      m_drop = 0; m_th = 0;
    end else begin
      sz = q.size();
      chk("full", 32'(full), 32'(sz == DEPTH));
      chk("empty", 32'(empty), 32'(sz == 0));
      chk("irq", 32'(irq), 32'(m_irq));
      chk("pready", 32'(pready), 32'd1);
      acc = psel && penable && m_setup;
      s = paddr[3:2];
      if (acc) begin
        exp_err = 0;
        exp_rd = 0;
        if (pwrite) exp_err = (s < 2);
        else begin
          case (s)
            2'd0: if (m_hasdata) exp_rd = 32'(q[0]); else exp_err = 1;
            2'd1: exp_rd = 32'(sz) | (sz == 0 ? 32'h10000 : 0) |
                           (sz == DEPTH ? 32'h20000 : 0) |
                           (m_ovf ? 32'h40000 : 0) | (32'(m_drop) << 24);
            2'd2: exp_rd = 32'(m_en);
            default: exp_rd = 32'(m_th);
          endcase
          chk("prdata", prdata, exp_rd);
        end
        chk("pslverr", 32'(pslverr), 32'(exp_err));
      end
      push = wr_valid && m_en && sz < DEPTH;
      dropev = wr_valid && m_en && sz == DEPTH;
      pop = acc && !pwrite && s == 0 && m_hasdata;
      ctrlw = acc && pwrite && s == 2;
      if (pop) void'(q.pop_front());
      if (push) q.push_back(wr_data);
      if (ctrlw && pwdata[1]) q.delete();
      if (ctrlw && pwdata[2]) begin
        m_ovf = 0; m_drop = 0;
      end else if (dropev) begin
        m_ovf = 1;
        if (m_drop < 255) m_drop++;
      end
      if (ctrlw) m_en = pwdata[0];
`ifdef CAPTURE_FIFO_THRESH_IRQ_EN
      if (acc && pwrite && s == 3) m_th = int'(pwdata % (2 * DEPTH));
      m_irq = m_en && q.size() >= m_th && m_th != 0;
`endif
      m_hasdata = (sz != 0);
      m_setup = psel && !penable;
    end
  end

  always @(posedge clk) begin
    if (push_mode) begin
      #1;
      wr_valid = 1'($urandom_range(0, 1));
      wr_data = 16'($urandom);
    end
  end

  task automatic push1(input logic [15:0] d);
    @(posedge clk); #1;
    wr_valid = 1; wr_data = d;
    @(posedge clk); #1;
    wr_valid = 0;
  endtask

  task automatic apb_read(input logic [3:0] a, input bit dp,
                          input logic [15:0] pd,
                          output logic [31:0] rd, output logic err);
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = 0; paddr = a;
    @(posedge clk); #1;
    penable = 1;
    if (!push_mode) begin wr_valid = dp; wr_data = pd; end
    @(negedge clk);
    rd = prdata; err = pslverr;
    @(posedge clk); #1;
    psel = 0; penable = 0;
    if (!push_mode) wr_valid = 0;
  endtask

  task automatic apb_write(input logic [3:0] a, input logic [31:0] d,
                           output logic err);
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1;
    @(negedge clk);
    err = pslverr;
    @(posedge clk); #1;
    psel = 0; penable = 0; pwrite = 0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic e;
    int r;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    apb_read(4'h4, 0, 0, d, e);
    chk("rst_status", d, 32'h0001_0000);
    chk("rst_pslverr", 32'(e), 0);

    apb_write(4'h8, 32'h1, e);
    push1(16'h1234);
    push1(16'hABCD);
    apb_read(4'h0, 0, 0, d, e);
    chk("rd_1234", d, 32'h0000_1234);
    apb_read(4'h0, 0, 0, d, e);
    chk("rd_abcd", d, 32'h0000_ABCD);
    @(negedge clk);
    chk("empty_after2", 32'(empty), 1);

    for (int i = 0; i < 6; i++) push1(16'h0A00 + 16'(i));
    @(negedge clk);
    chk("full_6", 32'(full), 1);
    apb_read(4'h4, 0, 0, d, e);
    chk("status_ovf", d, 32'h0206_0004);
    for (int i = 0; i < 4; i++) begin
      apb_read(4'h0, 0, 0, d, e);
      chk("rd_order", d, 32'h0A00 + 32'(i));
    end

    apb_read(4'h0, 0, 0, d, e);
    chk("rd_empty_data", d, 0);
    chk("rd_empty_err", 32'(e), 1);
    for (int i = 0; i < 4; i++) push1(16'h0B00 + 16'(i));
    apb_write(4'h8, 32'h2, e);
    @(negedge clk);
    chk("flush_empty", 32'(empty), 1);
    apb_read(4'h4, 0, 0, d, e);
    chk("flush_status", d, 32'h0205_0000);
    apb_write(4'h4, 32'h0, e);
    chk("wr_status_err", 32'(e), 1);
    apb_write(4'h8, 32'h5, e);
    apb_read(4'h4, 0, 0, d, e);
    chk("clr_status", d, 32'h0001_0000);

    for (int i = 0; i < 3; i++) push1(16'h0C00 + 16'(i));
    for (int i = 0; i < 10; i++) begin
      apb_read(4'h0, 1, 16'h0D00 + 16'(i), d, e);
      chk("wrap_order", d,
          i < 3 ? 32'h0C00 + 32'(i) : 32'h0D00 + 32'(i - 3));
    end
    apb_read(4'h4, 0, 0, d, e);
    chk("wrap_level", d, 32'h0000_0003);
    apb_write(4'h8, 32'h3, e);

    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = 0; paddr = 4'h0; rst = 1;
    @(posedge clk); #1;
    rst = 0; penable = 1;
    @(negedge clk);
    chk("abort_pslverr", 32'(pslverr), 0);
    @(posedge clk); #1;
    psel = 0; penable = 0;
    apb_write(4'h8, 32'h1, e);

    apb_write(4'hC, 32'h3, e);
    for (int i = 0; i < 3; i++) push1(16'h0E00 + 16'(i));
    @(negedge clk);
`ifdef CAPTURE_FIFO_THRESH_IRQ_EN
    chk("irq_set", 32'(irq), 1);
    apb_read(4'h0, 0, 0, d, e);
    @(negedge clk);
    chk("irq_clear", 32'(irq), 0);
`else
    chk("irq_off", 32'(irq), 0);
    apb_read(4'hC, 0, 0, d, e);
    chk("thresh_off", d, 0);
`endif
    apb_write(4'h8, 32'h3, e);

    push_mode = 1;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: apb_read(4'h0, 0, 0, d, e);
        4: apb_read(4'h4, 0, 0, d, e);
        5: begin
          r = $urandom_range(0, 9);
          apb_write(4'h8, r < 6 ? 32'h1 : r < 7 ? 32'h3 :
                          r < 8 ? 32'h5 : r < 9 ? 32'h0 : 32'h7, e);
        end
        6: apb_write(4'hC, 32'($urandom_range(0, 7)), e);
        7: apb_write(4'($urandom_range(0, 1) * 4), $urandom, e);
        8: apb_read(4'h8, 0, 0, d, e);
        default: apb_read(4'hC, 0, 0, d, e);
      endcase
    end
    push_mode = 0;
    @(posedge clk); #1 wr_valid = 0;
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
